// File: rtl/score_tracker.sv
// Multi-channel score tracker: combo multiplier, saturating score/hits, shot-miss detection.
// Optional session high score is built only when HIGH_SCORE_EN is defined.
module score_tracker #(
  parameter int unsigned SCORE_W   = 32,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PTS_W     = 8,
  parameter int unsigned COMBO_MAX = 4,
  parameter int unsigned HIT_WIN   = 16
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic [1:0]                         state,
  input  logic [NUM_CH-1:0]                  bird_shot,
  input  logic                               trigger,
  input  logic [PTS_W-1:0]                   pts_base,
  input  logic                               clear_score,
  output logic [SCORE_W-1:0]                 score,
  output logic [SCORE_W-1:0]                 high_score,
  output logic [$clog2(COMBO_MAX+1)-1:0]     combo,
  output logic [7:0]                         hits,
  output logic                               miss
);

  localparam int unsigned CW  = $clog2(COMBO_MAX + 1);
  localparam int unsigned AW  = SCORE_W + PTS_W;
  localparam int unsigned SW1 = AW + 1;
  localparam int unsigned PCW = $clog2(NUM_CH + 1);
  localparam int unsigned TW  = (HIT_WIN > 1) ? $clog2(HIT_WIN) : 1;

  typedef enum logic {S_IDLE, S_WINDOW} shot_e;

  shot_e               shot_q, shot_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]   prev_shot_q;
  logic                prev_trig_q;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CW-1:0]       combo_q, combo_d;
  logic [7:0]          hits_q, hits_d;
  logic                miss_q, miss_d;

  logic [NUM_CH-1:0]   hit_edge;
  logic                trig_edge;
  logic                any_hit;
  logic                play;
  logic [PCW-1:0]      hit_cnt;
  logic [AW-1:0]       add_c;
  logic [SW1-1:0]      sum_c;
  logic [8:0]          hsum_c;

  function automatic logic [PCW-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  assign hit_edge  = bird_shot & ~prev_shot_q;
  assign trig_edge = trigger & ~prev_trig_q;
  assign any_hit   = |hit_edge;
  assign play      = (state == 2'b01);
  assign hit_cnt   = popcnt(hit_edge);

  // Multiplier uses the combo level held before this cycle's increment.
  assign add_c  = AW'(pts_base) * (AW'(combo_q) + AW'(1)) * AW'(hit_cnt);
  assign sum_c  = SW1'(score_q) + SW1'(add_c);
  assign hsum_c = 9'(hits_q) + 9'(hit_cnt);

  always_comb begin
    shot_d  = shot_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    combo_d = combo_q;
    hits_d  = hits_q;
    miss_d  = 1'b0;
    if (clear_score) begin
      shot_d  = S_IDLE;
      score_d = '0;
      combo_d = '0;
      hits_d  = '0;
    end else if (play) begin
      score_d = (|sum_c[SW1-1:SCORE_W]) ? {SCORE_W{1'b1}} : sum_c[SCORE_W-1:0];
      hits_d  = hsum_c[8] ? 8'hFF : hsum_c[7:0];
      if (any_hit && (combo_q != CW'(COMBO_MAX))) combo_d = combo_q + CW'(1);
      case (shot_q)
        S_IDLE: begin
          if (trig_edge) begin
            shot_d = S_WINDOW;
            cnt_d  = TW'(HIT_WIN - 1);
          end
        end
        S_WINDOW: begin
          if (any_hit) begin
            shot_d = S_IDLE;
          end else if (trig_edge) begin
            cnt_d   = TW'(HIT_WIN - 1);
            miss_d  = 1'b1;
            combo_d = '0;
          end else if (cnt_q == '0) begin
            shot_d  = S_IDLE;
            miss_d  = 1'b1;
            combo_d = '0;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: shot_d = S_IDLE;
      endcase
    end else begin
      shot_d = S_IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shot_q      <= S_IDLE;
      cnt_q       <= '0;
      prev_shot_q <= '0;
      prev_trig_q <= 1'b0;
      score_q     <= '0;
      combo_q     <= '0;
      hits_q      <= '0;
      miss_q      <= 1'b0;
    end else begin
      shot_q      <= shot_d;
      cnt_q       <= cnt_d;
      prev_shot_q <= bird_shot;
      prev_trig_q <= trigger;
      score_q     <= score_d;
      combo_q     <= combo_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
    end
  end

  assign score = score_q;
  assign combo = combo_q;
  assign hits  = hits_q;
  assign miss  = miss_q;

`ifdef HIGH_SCORE_EN
  logic [1:0]         state_q;
  logic [SCORE_W-1:0] hs_q, hs_d;

  // Captured on entry to GAME_OVER from the registered score.
  always_comb begin
    hs_d = hs_q;
    if ((state == 2'b11) && (state_q != 2'b11) && (score_q > hs_q)) hs_d = score_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= 2'b00;
      hs_q    <= '0;
    end else begin
      state_q <= state;
      hs_q    <= hs_d;
    end
  end

  assign high_score = hs_q;
`else
  assign high_score = '0;
`endif

endmodule
